sipo: RTL
=========

SIPO -- requirements
Module: sipo

Interface
REQ-001 Parameter: WIDTH, default 32, meaning word length in bits (SHALL be at least 2).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  SHALL be high in the cycle carrying bit 0 of a new word.
REQ-005 Port: data_in  input  1  serial data, LSB first, sampled on each rising clk edge.
REQ-006 Port: out_ready  input  1  consumer accepts data_out when high with out_valid.
REQ-007 Port: ovr_clr  input  1  clears the sticky overrun flag.
REQ-008 Port: data_out  output  WIDTH  assembled parallel word.
REQ-009 Port: out_valid  output  1  data_out holds an unconsumed word.
REQ-010 Port: busy  output  1  a word is partially received (state SHIFT).
REQ-011 Port: overrun  output  1  sticky flag indicating a completed word was dropped.

Function
REQ-012 The block SHALL implement the states IDLE and SHIFT, a shift register of WIDTH bits, a bit counter of ceil(log2(WIDTH)) bits, and a separate output holding register.
REQ-013 In IDLE with start=1, the block SHALL store data_in as bit 0, set the counter to 1, and go to SHIFT; with start=0, data_in SHALL be ignored.
REQ-014 In SHIFT with start=0, each edge SHALL store data_in at bit position = counter and increment the counter.
REQ-015 The bit for counter = WIDTH-1 SHALL complete the word, and the state SHALL return to IDLE on that edge.
REQ-016 start=1 in SHIFT SHALL abort the partial word without flagging it, take data_in as bit 0 of a new word, and set the counter to 1.
REQ-017 The bit order SHALL be: the bit sampled k cycles after the start cycle lands in data_out[k], for k = 0..WIDTH-1.
REQ-018 On word completion, the full word SHALL be written into data_out and out_valid SHALL be set on the same edge as the last bit is sampled, giving out_valid high WIDTH cycles after the start cycle.
REQ-019 A transfer SHALL occur on any edge where out_valid=1 and out_ready=1; out_valid SHALL then clear unless a new word completes on that same edge.
REQ-020 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be discarded, data_out SHALL be unchanged, and overrun SHALL be set.
REQ-021 If a word completes on the same edge as a transfer, the new word SHALL be loaded, out_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-022 data_out SHALL be stable whenever out_valid=1 and no transfer occurs.
REQ-023 ovr_clr=1 SHALL clear overrun; if a set condition occurs on the same edge, the set SHALL win.
REQ-024 busy SHALL equal 1 exactly while the state is SHIFT.
REQ-025 start=1 on the completion cycle of a word SHALL NOT arise, because completion requires start=0; that edge is handled per REQ-016 (abort and restart).
REQ-026 The block SHALL support back-to-back words, with start asserted in the cycle immediately after a completion, and SHALL lose no bits.

Reset
REQ-027 When rst=0, the block SHALL asynchronously force: state IDLE, counter 0, shift register 0, data_out 0, out_valid 0, busy 0, overrun 0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after rst deasserts, the block SHALL remain in IDLE until a start is seen.
REQ-029 The block SHALL leave IDLE only on the first clk edge after rst deasserts at which start=1.

Verification
REQ-030 Basic word: start plus 32 bits of 0xA5C3_0F81 (LSB first) with out_ready=1 -> out_valid high for 1 cycle, WIDTH cycles after start, with data_out=0xA5C30F81.
REQ-031 Back-to-back: words 0x0000_0001 then 0x8000_0000 sent with no gap and out_ready=1 -> two single-cycle out_valid pulses 32 cycles apart carrying the correct values; overrun=0.
REQ-032 Overrun: out_ready=0, send 0x1111_1111 then 0x2222_2222 -> data_out stays 0x11111111, overrun=1; then ovr_clr=1 -> overrun=0.
REQ-033 Simultaneous: out_valid=1 with 0x1111_1111, and out_ready=1 on the completion edge of 0x3333_3333 -> out_valid stays 1, data_out=0x33333333, overrun=0.
REQ-034 Abort: start, 10 bits, then start again followed by 0xDEAD_BEEF -> only 0xDEADBEEF is output, with 1 out_valid pulse.
REQ-035 Reset mid-word: rst=0 after 16 bits -> all outputs 0 immediately; a following full word of 0x1234_5678 -> data_out=0x12345678.

Source files
------------

// File: rtl/sipo.sv
// Serial-in / parallel-out receiver.
// Assembles WIDTH-bit words that arrive LSB first and are framed by a start
// pulse on bit 0. A completed word goes into a holding register that is offered
// through a valid/ready handshake. A word that completes while the holding
// register is still occupied is dropped, and a sticky overrun flag is raised.
module sipo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic             word_done;
  logic             xfer;
  logic [WIDTH-1:0] word_full;

  // The last bit is sampled on the completion edge itself, so the full word is
  // the stored low bits with the live data_in spliced in as the top bit.
  assign word_done = (state_q == SHIFT) && !start && (cnt_q == LAST);
  assign word_full = {data_in, sreg_q[WIDTH-2:0]};
  assign xfer      = out_valid && out_ready;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: a start always (re)enters SHIFT; the final bit returns to IDLE.
  // NOTE: state_d gets a default before the case statement. Without it, a path
  // that leaves state_d unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (start) state_d = SHIFT;
               else if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy marks a partially received word.
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // Shift register and bit counter. A start, whether in IDLE or as an abort in
  // SHIFT, always begins a new word at bit 0.
  // NOTE: the shift register is an ordinary bank of flops, not a RAM, so it is
  // cleared on reset. A stale partial word can never leak into a later one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      sreg_q[0] <= data_in;
      cnt_q     <= CW'(1);
    end else if (state_q == SHIFT) begin
      sreg_q[cnt_q] <= data_in;
      cnt_q         <= word_done ? '0 : cnt_q + CW'(1);
    end
  end

  // Holding register and valid flag. A completed word is loaded only when the
  // slot is empty or is being emptied on this same edge. Otherwise the slot is
  // left untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (word_done && (!out_valid || out_ready)) begin
      data_out  <= word_full;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun flag. A drop on the same edge as a clear request wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      overrun <= 1'b0;
    else if (word_done && out_valid && !out_ready) overrun <= 1'b1;
    else if (ovr_clr)                              overrun <= 1'b0;
  end

endmodule
